// File: rtl/pcie_tx_cpl.sv
// pcie_tx_cpl: builds and transmits a PCIe completion TLP (Cpl or CplD) on
// the 64-bit TRN TX interface. It captures the request header, reads one DW
// from target memory, then sends a 2-beat, 3DW-header packet.
module pcie_tx_cpl (
    input  logic        clk,
    input  logic        rst,

    input  logic        req_compl_i,
    input  logic        req_compl_with_data_i,
    input  logic [2:0]  req_tc_i,
    input  logic        req_td_i,
    input  logic        req_ep_i,
    input  logic [1:0]  req_attr_i,
    input  logic [9:0]  req_len_i,
    input  logic [15:0] req_rid_i,
    input  logic [7:0]  req_tag_i,
    input  logic [3:0]  req_be_i,
    input  logic [12:0] req_addr_i,
    input  logic [15:0] completer_id_i,

    output logic [10:0] rd_addr_o,
    output logic [3:0]  rd_be_o,
    input  logic [31:0] rd_data_i,

    output logic [63:0] trn_td_o,
    output logic [7:0]  trn_trem_n_o,
    output logic        trn_tsof_n_o,
    output logic        trn_teof_n_o,
    output logic        trn_tsrc_rdy_n_o,
    output logic        trn_tsrc_dsc_n_o,
    input  logic        trn_tdst_rdy_n_i,

    output logic        compl_done_o
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, HDR, LAST} state_t;

    state_t state, state_nxt;

    // Captured request fields
    logic        wd_q;
    logic [2:0]  tc_q;
    logic        td_q;
    logic        ep_q;
    logic [1:0]  attr_q;
    logic [9:0]  len_q;
    logic [15:0] rid_q;
    logic [7:0]  tag_q;
    logic [3:0]  be_q;
    logic [10:0] addr_q;
    logic [15:0] cid_q;
    logic [31:0] data_q;

    // Next values of the registered TRN outputs
    logic [63:0] td_nxt;
    logic [7:0]  trem_nxt;
    logic        sof_nxt;
    logic        eof_nxt;
    logic        rdy_nxt;
    logic        done_nxt;

    logic [11:0] byte_count;
    logic [1:0]  lower_lo;
    logic [31:0] dw0, dw1, dw2;

    // The byte address low bits are replaced by the BE-derived offset.
    logic unused_addr_lsb;
    assign unused_addr_lsb = ^req_addr_i[1:0];

    // State register
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Capture request fields in IDLE and the memory read word on RD_WAIT exit
    always_ff @(posedge clk) begin
        if (rst) begin
            wd_q   <= 1'b0;
            tc_q   <= '0;
            td_q   <= 1'b0;
            ep_q   <= 1'b0;
            attr_q <= '0;
            len_q  <= '0;
            rid_q  <= '0;
            tag_q  <= '0;
            be_q   <= '0;
            addr_q <= '0;
            cid_q  <= '0;
            data_q <= '0;
        end else begin
            if (state == IDLE && req_compl_i) begin
                wd_q   <= req_compl_with_data_i;
                tc_q   <= req_tc_i;
                td_q   <= req_td_i;
                ep_q   <= req_ep_i;
                attr_q <= req_attr_i;
                len_q  <= req_len_i;
                rid_q  <= req_rid_i;
                tag_q  <= req_tag_i;
                be_q   <= req_be_i;
                addr_q <= req_addr_i[12:2];
                cid_q  <= completer_id_i;
            end
            if (state == RD_WAIT)
                data_q <= rd_data_i;
        end
    end

    assign rd_addr_o = addr_q;
    assign rd_be_o   = be_q;

    // Byte count and low address bits from first-DW byte enables
    always_comb begin
        byte_count = 12'd1;
        casez (be_q)
            4'b1??1:                      byte_count = 12'd4;
            4'b01?1, 4'b1?10:             byte_count = 12'd3;
            4'b0011, 4'b0110, 4'b1100:    byte_count = 12'd2;
            default:                      byte_count = 12'd1;
        endcase
        lower_lo = 2'b00;
        casez (be_q)
            4'b???1: lower_lo = 2'b00;
            4'b??10: lower_lo = 2'b01;
            4'b?100: lower_lo = 2'b10;
            4'b1000: lower_lo = 2'b11;
            default: lower_lo = 2'b00;
        endcase
    end

    assign dw0 = {1'b0, (wd_q ? 2'b10 : 2'b00), 5'b01010, 1'b0, tc_q, 4'h0,
                  td_q, ep_q, attr_q, 2'b00, len_q};
    assign dw1 = {cid_q, 3'b000, 1'b0, byte_count};
    assign dw2 = {rid_q, tag_q, 1'b0, addr_q[4:0], lower_lo};

    // Next-state logic; outputs are decoded from the next state so that they
    // can be registered and still line up with the state they belong to.
    always_comb begin
        state_nxt = state;
        td_nxt    = '0;
        trem_nxt  = '1;
        sof_nxt   = 1'b1;
        eof_nxt   = 1'b1;
        rdy_nxt   = 1'b1;
        done_nxt  = 1'b0;

        case (state)
            IDLE:    if (req_compl_i) state_nxt = RD_WAIT;
            RD_WAIT: state_nxt = HDR;
            HDR:     if (!trn_tdst_rdy_n_i) state_nxt = LAST;
            LAST: begin
                if (!trn_tdst_rdy_n_i) begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
            end
            default: state_nxt = IDLE;
        endcase

        case (state_nxt)
            HDR: begin
                td_nxt   = {dw0, dw1};
                trem_nxt = 8'h00;
                sof_nxt  = 1'b0;
                rdy_nxt  = 1'b0;
            end
            LAST: begin
                td_nxt   = {dw2, (wd_q ? data_q : 32'h0)};
                trem_nxt = wd_q ? 8'h00 : 8'h0F;
                eof_nxt  = 1'b0;
                rdy_nxt  = 1'b0;
            end
            default: ;
        endcase
    end

    // Registered TRN outputs and completion pulse
    always_ff @(posedge clk) begin
        if (rst) begin
            trn_td_o         <= '0;
            trn_trem_n_o     <= '1;
            trn_tsof_n_o     <= 1'b1;
            trn_teof_n_o     <= 1'b1;
            trn_tsrc_rdy_n_o <= 1'b1;
            compl_done_o     <= 1'b0;
        end else begin
            trn_td_o         <= td_nxt;
            trn_trem_n_o     <= trem_nxt;
            trn_tsof_n_o     <= sof_nxt;
            trn_teof_n_o     <= eof_nxt;
            trn_tsrc_rdy_n_o <= rdy_nxt;
            compl_done_o     <= done_nxt;
        end
    end

    assign trn_tsrc_dsc_n_o = 1'b1;

endmodule

// File: tb/tb_pcie_tx_cpl.sv
// Testbench for pcie_tx_cpl: directed vectors, BE sweep, corner sequences and
// randomized completions checked against a behavioural model.
module tb_pcie_tx_cpl;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_compl_i, req_compl_with_data_i;
    logic [2:0]  req_tc_i;
    logic        req_td_i, req_ep_i;
    logic [1:0]  req_attr_i;
    logic [9:0]  req_len_i;
    logic [15:0] req_rid_i;
    logic [7:0]  req_tag_i;
    logic [3:0]  req_be_i;
    logic [12:0] req_addr_i;
    logic [15:0] completer_id_i;
    logic [10:0] rd_addr_o;
    logic [3:0]  rd_be_o;
    logic [31:0] rd_data_i;
    logic [63:0] trn_td_o;
    logic [7:0]  trn_trem_n_o;
    logic        trn_tsof_n_o, trn_teof_n_o, trn_tsrc_rdy_n_o, trn_tsrc_dsc_n_o;
    logic        trn_tdst_rdy_n_i;
    logic        compl_done_o;

    int checks = 0;
    int errors = 0;

    localparam logic [15:0] CID = 16'hBEEF;

    always #5 clk = ~clk;

    pcie_tx_cpl dut (
        .clk(clk), .rst(rst),
        .req_compl_i(req_compl_i), .req_compl_with_data_i(req_compl_with_data_i),
        .req_tc_i(req_tc_i), .req_td_i(req_td_i), .req_ep_i(req_ep_i),
        .req_attr_i(req_attr_i), .req_len_i(req_len_i), .req_rid_i(req_rid_i),
        .req_tag_i(req_tag_i), .req_be_i(req_be_i), .req_addr_i(req_addr_i),
        .completer_id_i(completer_id_i),
        .rd_addr_o(rd_addr_o), .rd_be_o(rd_be_o), .rd_data_i(rd_data_i),
        .trn_td_o(trn_td_o), .trn_trem_n_o(trn_trem_n_o),
        .trn_tsof_n_o(trn_tsof_n_o), .trn_teof_n_o(trn_teof_n_o),
        .trn_tsrc_rdy_n_o(trn_tsrc_rdy_n_o), .trn_tsrc_dsc_n_o(trn_tsrc_dsc_n_o),
        .trn_tdst_rdy_n_i(trn_tdst_rdy_n_i), .compl_done_o(compl_done_o)
    );

    typedef struct {
        logic        wd;
        logic [2:0]  tc;
        logic        td;
        logic        ep;
        logic [1:0]  attr;
        logic [9:0]  len;
        logic [15:0] rid;
        logic [7:0]  tag;
        logic [3:0]  be;
        logic [12:0] addr;
        logic [31:0] data;
        int unsigned hs;   // stall cycles in HDR
        int unsigned ls;   // stall cycles in LAST
    } txn_t;

    typedef struct {
        txn_t        t;
        logic [63:0] b1;
        logic [63:0] b2;
    } vec_t;

    typedef struct {
        logic [3:0]  be;
        logic [11:0] bc;
        logic [1:0]  lo;
    } be_vec_t;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Beat assembly from byte count / address offset
    function automatic logic [63:0] pack_b1(input txn_t t, input logic [11:0] bc);
        logic [31:0] dw0;
        dw0 = {1'b0, (t.wd ? 2'b10 : 2'b00), 5'b01010, 1'b0, t.tc, 4'h0,
               t.td, t.ep, t.attr, 2'b00, t.len};
        return {dw0, CID, 4'h0, bc};
    endfunction

    function automatic logic [63:0] pack_b2(input txn_t t, input logic [1:0] lo);
        return {t.rid, t.tag, 1'b0, t.addr[6:2], lo, (t.wd ? t.data : 32'h0)};
    endfunction

    // Reference model: byte count spans lowest to highest enabled byte
    function automatic logic [11:0] model_bc(input logic [3:0] be);
        int lo = -1, hi = -1;
        for (int i = 0; i < 4; i++)
            if (be[i]) begin
                if (lo < 0) lo = i;
                hi = i;
            end
        if (lo < 0) return 12'd1;
        return 12'(hi - lo + 1);
    endfunction

    function automatic logic [1:0] model_lo(input logic [3:0] be);
        for (int i = 0; i < 4; i++)
            if (be[i]) return 2'(i);
        return 2'd0;
    endfunction

    task automatic scramble_req();
        req_compl_with_data_i = 1'($urandom);
        req_tc_i   = 3'($urandom);  req_td_i  = 1'($urandom);
        req_ep_i   = 1'($urandom);  req_attr_i = 2'($urandom);
        req_len_i  = 10'($urandom); req_rid_i = 16'($urandom);
        req_tag_i  = 8'($urandom);  req_be_i  = 4'($urandom);
        req_addr_i = 13'($urandom);
    endtask

    // Starts in the cycle the request is presented; ends in the done cycle.
    task automatic run_txn(input txn_t t, input logic [63:0] b1, input logic [63:0] b2,
                           input logic dup);
        logic [7:0] trem_exp;
        trem_exp = t.wd ? 8'h00 : 8'h0F;
        req_compl_i = 1'b1;
        req_compl_with_data_i = t.wd;
        req_tc_i = t.tc; req_td_i = t.td; req_ep_i = t.ep; req_attr_i = t.attr;
        req_len_i = t.len; req_rid_i = t.rid; req_tag_i = t.tag;
        req_be_i = t.be; req_addr_i = t.addr;
        step();
        req_compl_i = 1'b0;
        scramble_req();
        chk("rdwait_rdy", trn_tsrc_rdy_n_o, 1'b1);
        chk("rdwait_done", compl_done_o, 1'b0);
        chk("rd_addr", rd_addr_o, t.addr[12:2]);
        chk("rd_be", rd_be_o, t.be);
        rd_data_i = t.data;
        step();
        rd_data_i = $urandom;
        for (int unsigned i = 0; i <= t.hs; i++) begin
            chk("hdr_td", trn_td_o, b1);
            chk("hdr_ctl", {trn_tsof_n_o, trn_teof_n_o, trn_tsrc_rdy_n_o, trn_tsrc_dsc_n_o},
                4'b0101);
            chk("hdr_trem", trn_trem_n_o, 8'h00);
            chk("hdr_done", compl_done_o, 1'b0);
            if (dup && i == 0) begin
                scramble_req();
                req_compl_i = 1'b1;
            end
            trn_tdst_rdy_n_i = (i < t.hs);
            step();
            req_compl_i = 1'b0;
        end
        for (int unsigned j = 0; j <= t.ls; j++) begin
            chk("last_td", trn_td_o, b2);
            chk("last_ctl", {trn_tsof_n_o, trn_teof_n_o, trn_tsrc_rdy_n_o, trn_tsrc_dsc_n_o},
                4'b1001);
            chk("last_trem", trn_trem_n_o, trem_exp);
            chk("last_done", compl_done_o, 1'b0);
            trn_tdst_rdy_n_i = (j < t.ls);
            step();
        end
        trn_tdst_rdy_n_i = 1'($urandom);
        chk("done_pulse", compl_done_o, 1'b1);
        chk("done_rdy", trn_tsrc_rdy_n_o, 1'b1);
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) begin
            step();
            chk("idle_rdy", trn_tsrc_rdy_n_o, 1'b1);
            chk("idle_done", compl_done_o, 1'b0);
        end
    endtask

    function automatic txn_t rand_txn();
        txn_t t;
        t.wd = 1'($urandom); t.tc = 3'($urandom); t.td = 1'($urandom);
        t.ep = 1'($urandom); t.attr = 2'($urandom); t.len = 10'($urandom);
        t.rid = 16'($urandom); t.tag = 8'($urandom); t.be = 4'($urandom);
        t.addr = 13'($urandom); t.data = $urandom;
        t.hs = $urandom_range(0, 3); t.ls = $urandom_range(0, 3);
        return t;
    endfunction

    vec_t    dir[4];
    be_vec_t bev[16];

    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        txn_t t;

        dir[0].t = '{wd:1'b1, tc:3'd0, td:1'b0, ep:1'b0, attr:2'd0, len:10'd1,
                     rid:16'h1234, tag:8'h56, be:4'b1111, addr:13'h010,
                     data:32'hA5A5_0001, hs:0, ls:0};
        dir[0].b1 = 64'h4A00_0001_BEEF_0004;
        dir[0].b2 = 64'h1234_5610_A5A5_0001;
        dir[1].t = '{wd:1'b0, tc:3'd2, td:1'b0, ep:1'b0, attr:2'd1, len:10'd0,
                     rid:16'hABCD, tag:8'h01, be:4'b0110, addr:13'h007,
                     data:32'hDEAD_BEEF, hs:0, ls:0};
        dir[1].b1 = 64'h0A20_1000_BEEF_0002;
        dir[1].b2 = 64'hABCD_0105_0000_0000;
        dir[2] = dir[0];
        dir[2].t.hs = 3;
        dir[2].t.ls = 2;
        dir[3].t = '{wd:1'b1, tc:3'd7, td:1'b1, ep:1'b1, attr:2'd3, len:10'h3FF,
                     rid:16'h0001, tag:8'hFF, be:4'b1000, addr:13'h1FFF,
                     data:32'h1234_5678, hs:1, ls:1};
        dir[3].b1 = 64'h4A70_F3FF_BEEF_0001;
        dir[3].b2 = 64'h0001_FF7F_1234_5678;

        bev = '{'{4'b0000,12'd1,2'd0}, '{4'b0001,12'd1,2'd0}, '{4'b0010,12'd1,2'd1},
                '{4'b0011,12'd2,2'd0}, '{4'b0100,12'd1,2'd2}, '{4'b0101,12'd3,2'd0},
                '{4'b0110,12'd2,2'd1}, '{4'b0111,12'd3,2'd0}, '{4'b1000,12'd1,2'd3},
                '{4'b1001,12'd4,2'd0}, '{4'b1010,12'd3,2'd1}, '{4'b1011,12'd4,2'd0},
                '{4'b1100,12'd2,2'd2}, '{4'b1101,12'd4,2'd0}, '{4'b1110,12'd3,2'd1},
                '{4'b1111,12'd4,2'd0}};

        rst = 1'b1;
        req_compl_i = 1'b0;
        scramble_req();
        completer_id_i = CID;
        rd_data_i = '0;
        trn_tdst_rdy_n_i = 1'b0;
        step();
        step();
        chk("rst_td", trn_td_o, 64'h0);
        chk("rst_trem", trn_trem_n_o, 8'hFF);
        chk("rst_ctl", {trn_tsof_n_o, trn_teof_n_o, trn_tsrc_rdy_n_o, trn_tsrc_dsc_n_o},
            4'b1111);
        chk("rst_done", compl_done_o, 1'b0);
        rst = 1'b0;
        idle(2);

        // Directed vectors
        for (int i = 0; i < 4; i++) begin
            run_txn(dir[i].t, dir[i].b1, dir[i].b2, 1'b0);
            idle(1);
        end

        // Second request during HDR is ignored
        run_txn(dir[3].t, dir[3].b1, dir[3].b2, 1'b1);
        idle(6);

        // BE sweep
        for (int i = 0; i < 16; i++) begin
            t = rand_txn();
            t.be = bev[i].be;
            run_txn(t, pack_b1(t, bev[i].bc), pack_b2(t, bev[i].lo), 1'b0);
        end
        idle(1);

        // Reset asserted during LAST aborts without a done pulse
        t = dir[0].t;
        req_compl_i = 1'b1;
        req_compl_with_data_i = t.wd; req_tc_i = t.tc; req_td_i = t.td;
        req_ep_i = t.ep; req_attr_i = t.attr; req_len_i = t.len;
        req_rid_i = t.rid; req_tag_i = t.tag; req_be_i = t.be; req_addr_i = t.addr;
        step();
        req_compl_i = 1'b0;
        rd_data_i = t.data;
        trn_tdst_rdy_n_i = 1'b0;
        step();
        step();
        chk("abort_in_last", {trn_tsof_n_o, trn_teof_n_o, trn_tsrc_rdy_n_o}, 3'b100);
        trn_tdst_rdy_n_i = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        trn_tdst_rdy_n_i = 1'b0;
        chk("abort_rdy", trn_tsrc_rdy_n_o, 1'b1);
        chk("abort_ctl", {trn_tsof_n_o, trn_teof_n_o, trn_tsrc_dsc_n_o}, 3'b111);
        chk("abort_trem", trn_trem_n_o, 8'hFF);
        chk("abort_td", trn_td_o, 64'h0);
        chk("abort_done", compl_done_o, 1'b0);
        idle(4);
        run_txn(dir[1].t, dir[1].b1, dir[1].b2, 1'b0);

        // Randomized against the model, with back-to-back and gapped requests
        for (int n = 0; n < 60; n++) begin
            t = rand_txn();
            run_txn(t, pack_b1(t, model_bc(t.be)), pack_b2(t, model_lo(t.be)),
                    ($urandom_range(0, 7) == 0));
            idle($urandom_range(0, 2));
        end
        idle(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
